// File: rtl/mont_exp_ctrl_if.sv
// Bus interfaces for mont_exp_ctrl.
//  mont_exp_host_if : RSA top level <-> sequencer (operand load, start/busy/done/result)
//  mont_exp_mm_if   : sequencer <-> shared montgomery multiplier (start/done handshake)
// The "master" modport is the side that issues start; "slave" answers with done.
interface mont_exp_host_if #(
  parameter int N     = 1024,
  parameter int E_W   = 1024,
  parameter int LEN_W = 11
);
  logic             start;
  logic [N-1:0]     in_m;
  logic [N-1:0]     in_x_mont;
  logic [N-1:0]     in_one_mont;
  logic [E_W-1:0]   in_e;
  logic [LEN_W-1:0] e_len;
  logic             busy;
  logic             done;
  logic [N-1:0]     result;

  modport master (output start, in_m, in_x_mont, in_one_mont, in_e, e_len,
                  input  busy, done, result);
  modport slave  (input  start, in_m, in_x_mont, in_one_mont, in_e, e_len,
                  output busy, done, result);
endinterface

interface mont_exp_mm_if #(
  parameter int N = 1024
);
  logic         mm_start;
  logic [N-1:0] mm_in_a;
  logic [N-1:0] mm_in_b;
  logic [N-1:0] mm_in_m;
  logic [N-1:0] mm_result;
  logic         mm_done;

  modport master (output mm_start, mm_in_a, mm_in_b, mm_in_m,
                  input  mm_result, mm_done);
  modport slave  (input  mm_start, mm_in_a, mm_in_b, mm_in_m,
                  output mm_result, mm_done);
endinterface

// File: rtl/mont_exp_ctrl.sv
// mont_exp_ctrl: left-to-right binary modular exponentiation sequencer, r = x^e mod m.
// Drives an external montgomery multiplier (a*b*2^-N mod m): one square per exponent
// bit, one multiply per set bit, then a multiply-by-1 to leave the Montgomery domain.
// Optional build macro MONT_EXP_SKIP_LZ_EN: walk the leading zero bits without
// multiplier ops and load acc with x_mont at the first set bit.
module mont_exp_ctrl #(
  parameter int N     = 1024,
  parameter int E_W   = 1024,
  parameter int LEN_W = 11
) (
  input  logic            clk,
  input  logic            reset,
  mont_exp_host_if.slave  host,
  mont_exp_mm_if.master   mm
);
  localparam int IDX_W = $clog2(E_W);

  typedef enum logic [3:0] {
    IDLE, NEXT_BIT, SQ_START, SQ_WAIT, MUL_START, MUL_WAIT, POST_START, POST_WAIT, DONE
  } state_t;

  state_t           state, state_next;
  logic [N-1:0]     acc;
  logic [N-1:0]     x_mont;
  logic [E_W-1:0]   e_reg;
  logic [LEN_W-1:0] idx;
  logic [LEN_W-1:0] idx_m1;
  logic [LEN_W-1:0] len_clamped;
  logic             cur_bit;
  logic             lz_active;

  assign idx_m1      = idx - 1'b1;
  assign len_clamped = (host.e_len > LEN_W'(E_W)) ? LEN_W'(E_W) : host.e_len;
  // idx has already been decremented to the bit being processed when SQ_WAIT reads it.
  assign cur_bit     = e_reg[idx[IDX_W-1:0]];

`ifdef MONT_EXP_SKIP_LZ_EN
  logic lz;       // still inside the leading zeros of e
  logic nxt_bit;  // the bit NEXT_BIT is about to step onto
  assign nxt_bit   = e_reg[idx_m1[IDX_W-1:0]];
  assign lz_active = lz;
`else
  assign lz_active = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state decode.
  always_comb begin
    // NOTE: default assigned first, so every path through the case drives state_next and no latch is inferred.
    state_next = state;
    case (state)
      IDLE:       if (host.start) state_next = NEXT_BIT;
      NEXT_BIT: begin
        if (idx == '0)       state_next = POST_START;
        else if (!lz_active) state_next = SQ_START;
      end
      SQ_START:   state_next = SQ_WAIT;
      SQ_WAIT:    if (mm.mm_done) state_next = cur_bit ? MUL_START : NEXT_BIT;
      MUL_START:  state_next = MUL_WAIT;
      MUL_WAIT:   if (mm.mm_done) state_next = NEXT_BIT;
      POST_START: state_next = POST_WAIT;
      POST_WAIT:  if (mm.mm_done) state_next = DONE;
      DONE:       state_next = IDLE;
      default:    state_next = IDLE;
    endcase
  end

  // Datapath: operand latch, accumulator, multiplier operands and host outputs.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: the wide operand/accumulator registers are plain flops, not a memory, so they take the async reset too.
    if (reset) begin
      acc         <= '0;
      x_mont      <= '0;
      e_reg       <= '0;
      idx         <= '0;
      mm.mm_start <= 1'b0;
      mm.mm_in_a  <= '0;
      mm.mm_in_b  <= '0;
      mm.mm_in_m  <= '0;
      host.busy   <= 1'b0;
      host.done   <= 1'b0;
      host.result <= '0;
`ifdef MONT_EXP_SKIP_LZ_EN
      lz          <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking throughout, so every register here sees the pre-edge values of the others.
      mm.mm_start <= 1'b0;
      host.done   <= 1'b0;
      case (state)
        IDLE: begin
          if (host.start) begin
            mm.mm_in_m <= host.in_m;
            x_mont     <= host.in_x_mont;
            e_reg      <= host.in_e;
            acc        <= host.in_one_mont;
            idx        <= len_clamped;
            host.busy  <= 1'b1;
`ifdef MONT_EXP_SKIP_LZ_EN
            lz         <= 1'b1;
`endif
          end
        end
        NEXT_BIT: begin
          if (idx != '0) begin
            idx <= idx_m1;
`ifdef MONT_EXP_SKIP_LZ_EN
            // First set bit: x^1 in Montgomery form is x_mont itself, no op needed.
            if (lz && nxt_bit) begin
              acc <= x_mont;
              lz  <= 1'b0;
            end
`endif
          end
        end
        SQ_START: begin
          mm.mm_start <= 1'b1;
          mm.mm_in_a  <= acc;
          mm.mm_in_b  <= acc;
        end
        SQ_WAIT, MUL_WAIT: begin
          if (mm.mm_done) acc <= mm.mm_result;
        end
        MUL_START: begin
          mm.mm_start <= 1'b1;
          mm.mm_in_a  <= acc;
          mm.mm_in_b  <= x_mont;
        end
        POST_START: begin
          mm.mm_start <= 1'b1;
          mm.mm_in_a  <= acc;
          mm.mm_in_b  <= N'(1);
        end
        POST_WAIT: begin
          if (mm.mm_done) begin
            host.result <= mm.mm_result;
            host.done   <= 1'b1;
            host.busy   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mont_exp_ctrl.sv
// Self-checking bench for mont_exp_ctrl with a behavioural montgomery multiplier
// (a*b*2^-N mod m, fixed 20-cycle latency). Expected results come from a plain
// square-and-multiply reference and are queued at launch, popped at done.
`timescale 1ns/1ps
module tb_mont_exp_ctrl;
  localparam int N      = 1024;
  localparam int E_W    = 1024;
  localparam int LEN_W  = 11;
  localparam int MM_LAT = 20;
`ifdef MONT_EXP_SKIP_LZ_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mont_exp_host_if #(.N(N), .E_W(E_W), .LEN_W(LEN_W)) host ();
  mont_exp_mm_if   #(.N(N)) mm ();

  mont_exp_ctrl #(.N(N), .E_W(E_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset(reset), .host(host), .mm(mm)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [N-1:0] exp_q[$];

  typedef struct {
    logic [N-1:0]     m;
    logic [N-1:0]     x;
    logic [E_W-1:0]   e;
    logic [LEN_W-1:0] len;
    logic [N-1:0]     expv;
    int               ops;
  } case_t;

  // ---------------- reference arithmetic ----------------
  function automatic logic [N-1:0] mont_mul(input logic [N-1:0] a, b, m);
    logic [N+1:0] t;
    t = '0;
    for (int i = 0; i < N; i++) begin
      if (a[i]) t = t + {2'b00, b};
      if (t[0]) t = t + {2'b00, m};
      t = t >> 1;
    end
    if (t >= {2'b00, m}) t = t - {2'b00, m};
    return t[N-1:0];
  endfunction

  function automatic logic [N-1:0] to_mont(input logic [N-1:0] x, m);
    logic [N:0] r;
    r = {1'b0, x};
    for (int i = 0; i < N; i++) begin
      r = r << 1;
      if (r >= {1'b0, m}) r = r - {1'b0, m};
    end
    return r[N-1:0];
  endfunction

  function automatic logic [N-1:0] mod_mul(input logic [N-1:0] a, b, m);
    logic [N:0] r;
    r = '0;
    for (int i = N - 1; i >= 0; i--) begin
      r = r << 1;
      if (r >= {1'b0, m}) r = r - {1'b0, m};
      if (b[i]) begin
        r = r + {1'b0, a};
        if (r >= {1'b0, m}) r = r - {1'b0, m};
      end
    end
    return r[N-1:0];
  endfunction

  function automatic logic [N-1:0] mod_exp(input logic [N-1:0] x, input logic [E_W-1:0] e,
                                           input int len, input logic [N-1:0] m);
    logic [N-1:0] r;
    r = N'(1);
    for (int i = len - 1; i >= 0; i--) begin
      r = mod_mul(r, r, m);
      if (e[i]) r = mod_mul(r, x, m);
    end
    return r;
  endfunction

  // ---------------- behavioural multiplier ----------------
  logic         mm_pend;
  int           mm_timer;
  logic [N-1:0] cap_a, cap_b, cap_m, mm_prod;
  int           mm_total = 0;
  int           stab_err = 0;

  // Accepts mm_start, checks operand stability while busy, answers after MM_LAT cycles.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mm_pend      <= 1'b0;
      mm_timer     <= 0;
      mm.mm_done   <= 1'b0;
      mm.mm_result <= '0;
    end else begin
      mm.mm_done <= 1'b0;
      if (mm.mm_start) begin
        mm_pend  <= 1'b1;
        mm_timer <= MM_LAT - 1;
        cap_a    <= mm.mm_in_a;
        cap_b    <= mm.mm_in_b;
        cap_m    <= mm.mm_in_m;
        mm_prod  <= mont_mul(mm.mm_in_a, mm.mm_in_b, mm.mm_in_m);
        mm_total <= mm_total + 1;
      end else if (mm_pend) begin
        if (mm.mm_in_a !== cap_a || mm.mm_in_b !== cap_b || mm.mm_in_m !== cap_m)
          stab_err <= stab_err + 1;
        if (mm_timer == 0) begin
          mm_pend      <= 1'b0;
          mm.mm_done   <= 1'b1;
          mm.mm_result <= mm_prod;
        end else begin
          mm_timer <= mm_timer - 1;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic launch(input logic [N-1:0] m, x, input logic [E_W-1:0] e,
                        input logic [LEN_W-1:0] len, input logic [N-1:0] expv);
    @(negedge clk);
    host.in_m        = m;
    host.in_x_mont   = to_mont(x, m);
    host.in_one_mont = to_mont(N'(1), m);
    host.in_e        = e;
    host.e_len       = len;
    host.start       = 1'b1;
    exp_q.push_back(expv);
    @(negedge clk);
    host.start       = 1'b0;
    host.in_m        = '1;
    host.in_x_mont   = '1;
    host.in_one_mont = '1;
    host.in_e        = '1;
    host.e_len       = '1;
  endtask

  task automatic wait_done(input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (host.done === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    host.start = 1'b0; host.in_m = '0; host.in_x_mont = '0; host.in_one_mont = '0;
    host.in_e = '0; host.e_len = '0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (host.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", host.busy); end
    n_cmp++; if (host.done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", host.done); end
    n_cmp++; if (mm.mm_start !== 1'b0) begin n_bad++; $display("FAIL reset_mm_start got %b want 0", mm.mm_start); end
    n_cmp++; if (host.result !== '0) begin n_bad++; $display("FAIL reset_result low64 got %h want 0", host.result[63:0]); end
    n_cmp++; if (mm.mm_in_a !== '0 || mm.mm_in_b !== '0 || mm.mm_in_m !== '0) begin
      n_bad++; $display("FAIL reset_mm_operands got a=%h b=%h m=%h want 0", mm.mm_in_a[63:0], mm.mm_in_b[63:0], mm.mm_in_m[63:0]);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_table(input string tag, input case_t tv[$], input int budget);
    bit got;
    int snap;
    logic [N-1:0] expv;
    foreach (tv[k]) begin
      snap = mm_total;
      launch(tv[k].m, tv[k].x, tv[k].e, tv[k].len, tv[k].expv);
      n_cmp++; if (host.busy !== 1'b1) begin n_bad++; $display("FAIL %s[%0d] busy_after_accept got %b want 1", tag, k, host.busy); end
      wait_done(budget, got);
      n_cmp++;
      if (!got) begin
        n_bad++; $display("FAIL %s[%0d] done_timeout got no done want done within %0d cycles", tag, k, budget);
        exp_q.delete();
      end else begin
        expv = exp_q.pop_front();
        n_cmp++; if (host.result !== expv) begin n_bad++; $display("FAIL %s[%0d] result low64 got %h want %h", tag, k, host.result[63:0], expv[63:0]); end
        n_cmp++; if (host.busy !== 1'b0) begin n_bad++; $display("FAIL %s[%0d] busy_at_done got %b want 0", tag, k, host.busy); end
        n_cmp++; if (mm_total - snap != tv[k].ops) begin n_bad++; $display("FAIL %s[%0d] mm_ops got %0d want %0d", tag, k, mm_total - snap, tv[k].ops); end
        @(negedge clk);
        n_cmp++; if (host.done !== 1'b0) begin n_bad++; $display("FAIL %s[%0d] done_width got %b want 0", tag, k, host.done); end
      end
    end
  endtask

  task automatic test_known_vectors();
    case_t tv[$];
    tv.push_back('{N'(241), N'(3), E_W'(5), LEN_W'(3), N'(2), SKIP ? 4 : 6});
    tv.push_back('{N'(241), N'(3), E_W'(5), LEN_W'(8), N'(2), SKIP ? 4 : 11});
    run_table("known", tv, 2000);
  endtask

  task automatic test_random_exp();
    case_t tv[$];
    logic [N-1:0] m, x;
    for (int w = 0; w < N / 32; w++) begin
      m[w*32 +: 32] = $urandom;
      x[w*32 +: 32] = $urandom;
    end
    m[0] = 1'b1; m[N-1] = 1'b1; x[N-1] = 1'b0;
    tv.push_back('{m, x, E_W'(32'h10001), LEN_W'(17), mod_exp(x, E_W'(32'h10001), 17, m), SKIP ? 18 : 20});
    run_table("random", tv, 3000);
  endtask

  task automatic test_boundaries();
    case_t tv[$];
    tv.push_back('{N'(241), N'(3), E_W'(5), LEN_W'(0), N'(1), 1});
    tv.push_back('{N'(241), N'(3), E_W'(0), LEN_W'(8), N'(1), SKIP ? 1 : 9});
    tv.push_back('{N'(241), N'(3), E_W'(5), LEN_W'(2047), N'(2), SKIP ? 4 : 1027});
    run_table("boundary", tv, 40000);
  endtask

  task automatic test_mid_run();
    bit got, found;
    int snap, dones;
    logic [N-1:0] expv, xm;
    case_t tv[$];
    // start re-pulsed while a square is in flight
    snap = mm_total;
    launch(N'(241), N'(3), E_W'(5), LEN_W'(3), N'(2));
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (mm.mm_start === 1'b1) begin found = 1'b1; break; end
    end
    n_cmp++; if (!found) begin n_bad++; $display("FAIL midrun first_square got none want mm_start within 200 cycles"); end
    host.in_m = N'(251); host.in_x_mont = N'(7); host.in_one_mont = N'(5);
    host.in_e = '1; host.e_len = LEN_W'(9); host.start = 1'b1;
    @(negedge clk);
    host.start = 1'b0;
    wait_done(2000, got);
    n_cmp++;
    if (!got) begin
      n_bad++; $display("FAIL midrun_restart done_timeout got no done want done");
      exp_q.delete();
    end else begin
      expv = exp_q.pop_front();
      n_cmp++; if (host.result !== expv) begin n_bad++; $display("FAIL midrun_restart result low64 got %h want %h", host.result[63:0], expv[63:0]); end
      n_cmp++; if (mm_total - snap != (SKIP ? 4 : 6)) begin n_bad++; $display("FAIL midrun_restart mm_ops got %0d want %0d", mm_total - snap, SKIP ? 4 : 6); end
    end
    // reset while a multiply is in flight
    xm = to_mont(N'(3), N'(241));
    launch(N'(241), N'(3), E_W'(5), LEN_W'(3), N'(2));
    found = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (mm.mm_start === 1'b1 && mm.mm_in_b === xm && mm.mm_in_a !== mm.mm_in_b) begin found = 1'b1; break; end
    end
    n_cmp++; if (!found) begin n_bad++; $display("FAIL midrun mul_start got none want multiply within 400 cycles"); end
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    n_cmp++; if (host.busy !== 1'b0) begin n_bad++; $display("FAIL reset_in_mul busy got %b want 0", host.busy); end
    n_cmp++; if (mm.mm_start !== 1'b0) begin n_bad++; $display("FAIL reset_in_mul mm_start got %b want 0", mm.mm_start); end
    reset = 1'b0;
    dones = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (host.done === 1'b1) dones++;
    end
    n_cmp++; if (dones != 0) begin n_bad++; $display("FAIL reset_in_mul done_pulses got %0d want 0", dones); end
    // a fresh run after the reset
    tv.push_back('{N'(241), N'(3), E_W'(5), LEN_W'(8), N'(2), SKIP ? 4 : 11});
    run_table("after_reset", tv, 2000);
  endtask

  task automatic test_back_to_back();
    bit got;
    int snap, stab0, hold_bad;
    logic [N-1:0] expv, exp_b;
    stab0 = stab_err;
    launch(N'(241), N'(3), E_W'(5), LEN_W'(3), N'(2));
    wait_done(2000, got);
    n_cmp++;
    if (!got) begin
      n_bad++; $display("FAIL b2b_first done_timeout got no done want done");
      exp_q.delete();
    end else begin
      expv = exp_q.pop_front();
      n_cmp++; if (host.result !== expv) begin n_bad++; $display("FAIL b2b_first result low64 got %h want %h", host.result[63:0], expv[63:0]); end
    end
    // second run starts in the cycle right after done
    snap = mm_total;
    exp_b = mod_exp(N'(7), E_W'(11), 4, N'(241));
    launch(N'(241), N'(7), E_W'(11), LEN_W'(4), exp_b);
    n_cmp++; if (host.busy !== 1'b1) begin n_bad++; $display("FAIL b2b_second accepted got busy=%b want 1", host.busy); end
    hold_bad = 0;
    got = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (host.done === 1'b1) begin got = 1'b1; break; end
      if (host.result !== N'(2)) hold_bad++;
    end
    n_cmp++; if (hold_bad != 0) begin n_bad++; $display("FAIL b2b_result_hold got %0d changed cycles want 0", hold_bad); end
    n_cmp++;
    if (!got) begin
      n_bad++; $display("FAIL b2b_second done_timeout got no done want done");
      exp_q.delete();
    end else begin
      expv = exp_q.pop_front();
      n_cmp++; if (host.result !== expv) begin n_bad++; $display("FAIL b2b_second result low64 got %h want %h", host.result[63:0], expv[63:0]); end
      n_cmp++; if (mm_total - snap != (SKIP ? 6 : 8)) begin n_bad++; $display("FAIL b2b_second mm_ops got %0d want %0d", mm_total - snap, SKIP ? 6 : 8); end
    end
    n_cmp++; if (stab_err != stab0) begin n_bad++; $display("FAIL b2b operand_stability got %0d unstable cycles want 0", stab_err - stab0); end
    n_cmp++; if (stab_err != 0) begin n_bad++; $display("FAIL overall operand_stability got %0d unstable cycles want 0", stab_err); end
  endtask

  initial begin
    test_reset();
    test_known_vectors();
    test_random_exp();
    test_boundaries();
    test_mid_run();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got no completion want finish before 2 ms");
    $fatal(1, "watchdog expired");
  end
endmodule
